line_buffer_array: RTL and testbench

LINE_BUFFER_ARRAY -- requirements
Module: line_buffer_array

---
 rtl/line_buff_pkg.sv | 25 ++
 rtl/lbuff_sdp_ram.sv | 23 ++
 rtl/line_buffer_array.sv | 174 +++++++++++++++++
 tb/tb_line_buffer_array.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/line_buff_pkg.sv
// Shared fill-FSM state type and line geometry helpers
// for the tile line buffer array.
package line_buff_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LATCH,
      WRITE,
      DONE
   } fill_state_t;

   function automatic int tiles_per_line(int width_px, int tile_width);
      return width_px / tile_width;
   endfunction

   function automatic int rows_per_line(int tiles, int tiles_per_row);
      return tiles / tiles_per_row;
   endfunction

   function automatic int idx_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lbuff_sdp_ram.sv
// Simple dual-port tile RAM: one write port, one registered
// read port; a same-address collision returns the old word.
module lbuff_sdp_ram #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 160,
   parameter int AW    = 8
) (
   input  logic             clk_i,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/line_buffer_array.sv
// Round-robin filler for NUM_BUFFS tile line buffers from the
// frame buffer, plus a 2-cycle registered display read path.
module line_buffer_array
   import line_buff_pkg::*;
#(
   parameter int NUM_BUFFS        = 2,
   parameter int COLR_PXL_WIDTH   = 12,
   parameter int TILE_WIDTH       = 4,
   parameter int WIDTH_PX         = 640,
   parameter int TILES_PER_ROW    = 5,
   parameter int FBUFF_ADDR_WIDTH = 12,
   parameter int FBUFF_DEPTH      = 3840
) (
   input  logic                                    clk_i,
   input  logic                                    rstn_i,
   input  logic [NUM_BUFFS-1:0]                    buff_fill_req_i,
   input  logic [FBUFF_ADDR_WIDTH-1:0]             fbuff_line_addr_i,
   input  logic [$clog2(NUM_BUFFS)-1:0]            buff_sel_i,
   input  logic [$clog2(WIDTH_PX)-1:0]             disp_pxl_id_i,
   input  logic [TILES_PER_ROW*COLR_PXL_WIDTH-1:0] fbuff_data_i,
   output logic                                    fbuff_en_o,
   output logic [FBUFF_ADDR_WIDTH-1:0]             fbuff_addr_o,
   output logic [NUM_BUFFS-1:0]                    buff_fill_done_o,
   output logic                                    fill_busy_o,
   output logic [COLR_PXL_WIDTH-1:0]               disp_pxl_o
);

   localparam int TPL = tiles_per_line(WIDTH_PX, TILE_WIDTH);
   localparam int RPL = rows_per_line(TPL, TILES_PER_ROW);
   localparam int LAW = idx_w(TPL);
   localparam int KW  = idx_w(TILES_PER_ROW);
   localparam int RW  = idx_w(RPL);
   localparam int SW  = $clog2(NUM_BUFFS);
   localparam int DW  = TILES_PER_ROW * COLR_PXL_WIDTH;

   if (WIDTH_PX % TILE_WIDTH != 0 || TPL % TILES_PER_ROW != 0) begin : g_bad_geom
      $error("line_buffer_array: line width not a whole number of rows");
   end
   if (NUM_BUFFS < 2 || NUM_BUFFS > 4) begin : g_bad_nbuf
      $error("line_buffer_array: NUM_BUFFS must be 2..4");
   end

   fill_state_t state_q, state_d;

   logic [NUM_BUFFS-1:0]        pend_q;
   logic [NUM_BUFFS-1:0]        gnt_clr;
   logic [SW-1:0]               ptr_q;
   logic [SW-1:0]               gnt_q;
   logic [SW-1:0]               gnt_idx;
   logic                        found;
   logic [FBUFF_ADDR_WIDTH-1:0] addr_q;
   logic [DW-1:0]               word_q;
   logic [KW-1:0]               k_q;
   logic [RW-1:0]               row_q;
   logic                        k_last;
   logic                        row_last;
   logic                        grant;
   logic [LAW-1:0]              wr_addr;
   logic [COLR_PXL_WIDTH-1:0]   wr_data;

   // First pending buffer at or after the pointer, wrapping around.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_BUFFS; i++) begin
         if (!found && pend_q[(int'(ptr_q) + i) % NUM_BUFFS]) begin
            found   = 1'b1;
            gnt_idx = SW'((int'(ptr_q) + i) % NUM_BUFFS);
         end
      end
   end

   assign grant    = (state_q == IDLE) && found;
   assign k_last   = int'(k_q) == TILES_PER_ROW - 1;
   assign row_last = int'(row_q) == RPL - 1;

   always_comb begin
      gnt_clr = '0;
      if (grant) gnt_clr[gnt_idx] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (found) state_d = READ;
         READ:    state_d = LATCH;
         LATCH:   state_d = WRITE;
         WRITE:   if (k_last) state_d = row_last ? DONE : READ;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         pend_q  <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         addr_q  <= '0;
         word_q  <= '0;
         k_q     <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         // New pulses stay latched even for the buffer being filled.
         pend_q  <= (pend_q & ~gnt_clr) | buff_fill_req_i;
         if (grant) begin
            gnt_q  <= gnt_idx;
            ptr_q  <= (int'(gnt_idx) == NUM_BUFFS - 1) ? '0 : gnt_idx + 1'b1;
            addr_q <= fbuff_line_addr_i;
            k_q    <= '0;
            row_q  <= '0;
         end
         if (state_q == READ)
            addr_q <= (int'(addr_q) == FBUFF_DEPTH - 1) ? '0 : addr_q + 1'b1;
         if (state_q == LATCH) word_q <= fbuff_data_i;
         if (state_q == WRITE) begin
            k_q <= k_last ? '0 : k_q + 1'b1;
            if (k_last) row_q <= row_q + 1'b1;
         end
      end
   end

   always_comb begin
      buff_fill_done_o = '0;
      if (state_q == DONE) buff_fill_done_o[gnt_q] = 1'b1;
   end

   assign fbuff_en_o   = state_q == READ;
   assign fbuff_addr_o = addr_q;
   assign fill_busy_o  = state_q != IDLE;

   assign wr_addr = LAW'(int'(row_q) * TILES_PER_ROW + int'(k_q));
   assign wr_data = word_q[int'(k_q)*COLR_PXL_WIDTH +: COLR_PXL_WIDTH];

   logic [LAW-1:0]            rd_addr;
   logic                      in_rng;
   logic                      ok_q;
   logic [SW-1:0]             sel_q;
   logic [COLR_PXL_WIDTH-1:0] rd_data [NUM_BUFFS];

   assign rd_addr = LAW'(int'(disp_pxl_id_i) / TILE_WIDTH);
   assign in_rng  = (int'(disp_pxl_id_i) < WIDTH_PX)
                 && (int'(buff_sel_i) < NUM_BUFFS);

   for (genvar b = 0; b < NUM_BUFFS; b++) begin : g_buf
      lbuff_sdp_ram #(
         .WIDTH (COLR_PXL_WIDTH),
         .DEPTH (TPL),
         .AW    (LAW)
      ) u_ram (
         .clk_i   (clk_i),
         .we      ((state_q == WRITE) && (int'(gnt_q) == b)),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .rd_addr (rd_addr),
         .rd_data (rd_data[b])
      );
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ok_q       <= 1'b0;
         sel_q      <= '0;
         disp_pxl_o <= '0;
      end else begin
         ok_q       <= in_rng;
         sel_q      <= buff_sel_i;
         disp_pxl_o <= ok_q ? rd_data[sel_q] : '0;
      end
   end

endmodule

// File: tb/tb_line_buffer_array.sv
// Directed bench for line_buffer_array: fill timing, arbitration,
// address wrap, display path and reset abort.
module tb_line_buffer_array;

   localparam int NB  = 2;
   localparam int CW  = 12;
   localparam int TPR = 5;
   localparam int AW  = 12;
   localparam int DEP = 3840;

   logic              clk_i = 1'b0;
   logic              rstn_i = 1'b0;
   logic [NB-1:0]     buff_fill_req_i = '0;
   logic [AW-1:0]     fbuff_line_addr_i = '0;
   logic [0:0]        buff_sel_i = '0;
   logic [9:0]        disp_pxl_id_i = '0;
   logic [TPR*CW-1:0] fbuff_data_i = '0;
   logic              fbuff_en_o;
   logic [AW-1:0]     fbuff_addr_o;
   logic [NB-1:0]     buff_fill_done_o;
   logic              fill_busy_o;
   logic [CW-1:0]     disp_pxl_o;

   int n_chk = 0;
   int n_pass = 0;
   int rd_log[$];
   logic [NB-1:0] done_log[$];

   line_buffer_array dut (
      .clk_i             (clk_i),
      .rstn_i            (rstn_i),
      .buff_fill_req_i   (buff_fill_req_i),
      .fbuff_line_addr_i (fbuff_line_addr_i),
      .buff_sel_i        (buff_sel_i),
      .disp_pxl_id_i     (disp_pxl_id_i),
      .fbuff_data_i      (fbuff_data_i),
      .fbuff_en_o        (fbuff_en_o),
      .fbuff_addr_o      (fbuff_addr_o),
      .buff_fill_done_o  (buff_fill_done_o),
      .fill_busy_o       (fill_busy_o),
      .disp_pxl_o        (disp_pxl_o)
   );

   always #5 clk_i = ~clk_i;

   // Word n holds tiles n*5+k+1, tile 0 in the LSBs.
   function automatic logic [TPR*CW-1:0] word_of(int n);
      logic [TPR*CW-1:0] w;
      for (int k = 0; k < TPR; k++) w[k*CW +: CW] = CW'(n*TPR + k + 1);
      return w;
   endfunction

   always @(posedge clk_i) begin
      if (fbuff_en_o) begin
         rd_log.push_back(int'(fbuff_addr_o));
         fbuff_data_i <= word_of(int'(fbuff_addr_o));
      end
      if (|buff_fill_done_o) done_log.push_back(buff_fill_done_o);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
   endtask

   task automatic pulse_req(input logic [NB-1:0] m, input int a);
      buff_fill_req_i   = m;
      fbuff_line_addr_i = AW'(a);
      @(negedge clk_i);
      buff_fill_req_i = '0;
   endtask

   task automatic wait_done(input int start, input int lim, output int n);
      n = start;
      while (buff_fill_done_o == '0 && n < lim) begin
         @(negedge clk_i);
         n++;
      end
   endtask

   task automatic pix(input logic s, input int id, input int exp,
                      input string tag);
      buff_sel_i    = s;
      disp_pxl_id_i = 10'(id);
      repeat (2) @(negedge clk_i);
      check(tag, disp_pxl_o, exp);
   endtask

   initial begin
      int n;
      int base;
      repeat (3) @(negedge clk_i);
      check("rst_busy", fill_busy_o, 0);
      check("rst_en", fbuff_en_o, 0);
      check("rst_addr", fbuff_addr_o, 0);
      check("rst_done", buff_fill_done_o, 0);
      check("rst_disp", disp_pxl_o, 0);
      rstn_i = 1'b1;
      @(negedge clk_i);

      // Single fill of buffer 0 from line address 0
      pulse_req(2'b01, 0);
      wait_done(1, 400, n);
      check("a_latency", n, 226);
      check("a_done", buff_fill_done_o, 2'b01);
      check("a_nreads", rd_log.size(), 32);
      for (int i = 0; i < 32; i++) check("a_addr", rd_log[i], i);
      pix(0, 148, 38, "a_tile37");
      pix(0, 0, 1, "a_tile0");
      pix(0, 639, 160, "a_tile159");
      pix(0, 700, 0, "a_oor700");

      // Simultaneous requests after reset: buffer 0 then buffer 1
      rstn_i = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      rd_log.delete();
      base = done_log.size();
      pulse_req(2'b11, 500);
      wait_done(1, 400, n);
      check("b_lat0", n, 226);
      check("b_done0", buff_fill_done_o, 2'b01);
      @(negedge clk_i);
      check("b_grant_idle", fill_busy_o, 0);
      @(negedge clk_i);
      check("b_read_en", fbuff_en_o, 1);
      check("b_read_addr", fbuff_addr_o, 500);
      wait_done(2, 400, n);
      check("b_lat1", n, 226);
      check("b_done1", buff_fill_done_o, 2'b10);
      @(negedge clk_i);
      check("b_ndone", done_log.size() - base, 2);
      check("b_nreads", rd_log.size(), 64);

      // Sweep buffer 1 while buffer 0 is being refilled
      buff_sel_i = 1'b1;
      base = done_log.size();
      pulse_req(2'b01, 0);
      for (int i = 0; i < 642; i++) begin
         if (i >= 2) check("d_pix", disp_pxl_o, 2501 + (i - 2) / 4);
         if (i < 640) disp_pxl_id_i = 10'(i);
         @(negedge clk_i);
      end
      check("d_ndone", done_log.size() - base, 1);
      check("d_done", done_log[base], 2'b01);

      // Frame-buffer address wrap
      rd_log.delete();
      pulse_req(2'b10, 3830);
      wait_done(1, 400, n);
      check("c_latency", n, 226);
      check("c_done", buff_fill_done_o, 2'b10);
      check("c_nreads", rd_log.size(), 32);
      for (int i = 0; i < 32; i++) check("c_addr", rd_log[i], (3830 + i) % DEP);

      // Reset in the middle of row 10
      buff_sel_i    = 1'b0;
      disp_pxl_id_i = 10'd600;
      rd_log.delete();
      pulse_req(2'b01, 200);
      n = 0;
      while (rd_log.size() < 11 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      check("e_row10", rd_log.size(), 11);
      check("e_disp_pre", disp_pxl_o, 151);
      rstn_i = 1'b0;
      #1;
      check("e_busy", fill_busy_o, 0);
      check("e_en", fbuff_en_o, 0);
      check("e_addr", fbuff_addr_o, 0);
      check("e_done", buff_fill_done_o, 0);
      check("e_disp", disp_pxl_o, 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      base = done_log.size();
      repeat (300) @(negedge clk_i);
      check("e_nodone", done_log.size() - base, 0);
      check("e_idle", fill_busy_o, 0);
      check("e_ram_kept", disp_pxl_o, 151);
      rd_log.delete();
      pulse_req(2'b01, 200);
      wait_done(1, 400, n);
      check("e_latency", n, 226);
      check("e_nreads", rd_log.size(), 32);
      check("e_first", rd_log[0], 200);
      check("e_last", rd_log[31], 231);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
